alu_const_select_encoder: RTL and testbench
===========================================

Name: alu_const_select_encoder

Overview:
- Inverse of the ALU constant-input mux. Accepts a 16-bit constant request and emits a sequence of one-hot PA_Select beats; the ORed Low values of these beats reproduce the requested constant.
- Sits between the microcode/immediate stage and the decoder board that drives the PA_Select lines.
- The board drives at most one select line per cycle, so multi-bit constants are built over several beats with a valid/ready handshake.

Parameters:
- SEL_W, 18, width of select vector (fixed mapping below; not to be changed)
- MAX_BEATS, 8, depth of beat counter (saturating status only)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  constant request valid
- req_ready  output  1  encoder can accept a request
- req_value  input  16  requested constant
- sel_valid  output  1  beat valid
- sel_ready  input  1  downstream accepts beat
- sel  output  18  one-hot select: [0]=0x1_high [1]=0xffOP [2]=0x1 [3]=0x8 [4]=0x10 [5]=0x18 [6]=0x20 [7]=0x28 [8]=0x30 [9]=0x38 [10]=0x66 [11]=0xaa [12]=0x06 [13]=0x60 [14]=0x2 [15]=0x4 [16]=0x40 [17]=0x80
- sel_last  output  1  final beat of current request
- err  output  1  request not encodable (valid with sel_valid)
- beat_cnt  output  4  beats emitted for current request (saturates at MAX_BEATS)

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, sel_valid=0, sel=0, sel_last=0, err=0, beat_cnt=0.
- FSM states: IDLE, RUN.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch remaining mask rem=req_value[7:0] and hflag=(req_value[15:8]==8'hFF), then go to RUN.
  - First beat has sel_valid=1 on the next cycle (latency 1).
- RUN:
  - req_ready=0.
  - Beat order: the 0xffOP beat (sel[1]) first if hflag; then low-byte beats by greedy subset selection.
- Greedy priority: 0xaa, 0x66, 0x38, 0x60, 0x30, 0x28, 0x18, 0x06, 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01.
  - Pick the first entry E with (E & ~rem)==0, then rem <= rem & ~E.
  - Because the list is ordered by descending popcount, an exact table match is always a single beat.
- Exactly one sel bit is set per normal beat.
- sel_last=1 on the beat after which no 0xffOP beat is pending and rem==0.
- Handshake:
  - sel, sel_last, err and sel_valid hold stable while sel_valid&!sel_ready.
  - A beat advances only on sel_valid&sel_ready.
  - After the last beat is accepted, the FSM returns to IDLE and req_ready=1 on the following cycle; there is no back-to-back overlap.
- Value 0x0000: single beat, sel=0, sel_last=1, err=0.
- High byte neither 0x00 nor 0xFF: single beat, sel=0, err=1, sel_last=1; no select asserted.
- Value 0xFF00: single beat sel[1], sel_last=1.
- beat_cnt: cleared on request accept; increments on each accepted beat; saturates at MAX_BEATS.
- req_value is sampled only at accept; changes while in RUN are ignored.
- rst_n asserted mid-sequence: immediate abort to reset values; the partial sequence is discarded and not resumed.

Optional Feature:
- Macro ALU_CONST_HIGH_EN.
- Defined:
  - Adds input req_high (1 bit), sampled at accept.
  - If req_high=1, a sel[0] (0x1_high) beat is emitted before any other beat.
  - Value 0 with req_high=1 gives a single sel[0] beat with sel_last=1.
- Undefined: port absent and sel[0] is tied to 0.

Test Plan:
- Reset mid-RUN (value 0x00FF, after 2 beats) -> all outputs immediately 0, req_ready=1 after release, next request starts clean with beat_cnt=0.
- req_value=0x0066, sel_ready=1 -> one beat one cycle after accept: sel[10]=1, sel_last=1, err=0, beat_cnt=1.
- req_value=0xFFFF, sel_ready=1 -> 6 beats: sel[1], sel[11](0xaa), sel[16](0x40), sel[4](0x10), sel[15](0x04), sel[2](0x01); last flagged on beat 6.
- req_value=0x00FF, sel_ready toggled 1/0 each cycle -> 5 beats (0xaa, 0x40, 0x10, 0x04, 0x01), each held stable while sel_ready=0; req_ready stays 0 until the last beat is accepted.
- req_value=0x1234 -> single beat sel=0, err=1, sel_last=1; req_value=0x0000 -> single beat sel=0, err=0, sel_last=1.
- With ALU_CONST_HIGH_EN, req_value=0x0028, req_high=1 -> beats sel[0] then sel[7], sel_last on 2nd.

Source files
------------

// File: rtl/alu_const_select_encoder.sv
// Constant request -> one-hot PA_Select beat sequencer.
// Ports: clk, rst_n (async low), req_* in, sel_* out, err, beat_cnt.
// Optional: ALU_CONST_HIGH_EN adds req_high and the sel[0] beat.
module alu_const_select_encoder #(
  parameter int SEL_W     = 18,
  parameter int MAX_BEATS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_value,
`ifdef ALU_CONST_HIGH_EN
  input  logic             req_high,
`endif
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [SEL_W-1:0] sel,
  output logic             sel_last,
  output logic             err,
  output logic [3:0]       beat_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Greedy table, widest patterns first.
  function automatic logic [7:0] g_val(
    input logic [3:0] i
  );
    unique case (i)
      4'd0:    g_val = 8'haa;
      4'd1:    g_val = 8'h66;
      4'd2:    g_val = 8'h38;
      4'd3:    g_val = 8'h60;
      4'd4:    g_val = 8'h30;
      4'd5:    g_val = 8'h28;
      4'd6:    g_val = 8'h18;
      4'd7:    g_val = 8'h06;
      4'd8:    g_val = 8'h80;
      4'd9:    g_val = 8'h40;
      4'd10:   g_val = 8'h20;
      4'd11:   g_val = 8'h10;
      4'd12:   g_val = 8'h08;
      4'd13:   g_val = 8'h04;
      4'd14:   g_val = 8'h02;
      default: g_val = 8'h01;
    endcase
  endfunction

  // Select line driving the matching table entry.
  function automatic logic [4:0] g_idx(
    input logic [3:0] i
  );
    unique case (i)
      4'd0:    g_idx = 5'd11;
      4'd1:    g_idx = 5'd10;
      4'd2:    g_idx = 5'd9;
      4'd3:    g_idx = 5'd13;
      4'd4:    g_idx = 5'd8;
      4'd5:    g_idx = 5'd7;
      4'd6:    g_idx = 5'd5;
      4'd7:    g_idx = 5'd12;
      4'd8:    g_idx = 5'd17;
      4'd9:    g_idx = 5'd16;
      4'd10:   g_idx = 5'd6;
      4'd11:   g_idx = 5'd4;
      4'd12:   g_idx = 5'd3;
      4'd13:   g_idx = 5'd15;
      4'd14:   g_idx = 5'd14;
      default: g_idx = 5'd2;
    endcase
  endfunction

  logic [0:0] state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic       hflag_q, hflag_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic       high_pend;

`ifdef ALU_CONST_HIGH_EN
  logic high_q, high_d;
  assign high_pend = high_q;
`else
  assign high_pend = 1'b0;
`endif

  logic [7:0] pick_val;
  logic [4:0] pick_idx;
  logic       found;

  always_comb begin
    pick_val = 8'h00;
    pick_idx = 5'd0;
    found    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found &&
          (g_val(4'(i)) & ~rem_q) == 8'h00) begin
        found    = 1'b1;
        pick_val = g_val(4'(i));
        pick_idx = g_idx(4'(i));
      end
    end
  end

  logic [SEL_W-1:0] beat_sel;
  logic             beat_last;

  // Beat content is a pure function of held state,
  // so it stays stable while stalled.
  always_comb begin
    beat_sel  = '0;
    beat_last = 1'b0;
    if (err_q) begin
      beat_last = 1'b1;
    end else if (high_pend) begin
      beat_sel[0] = 1'b1;
      beat_last   = !hflag_q && rem_q == 8'h00;
    end else if (hflag_q) begin
      beat_sel[1] = 1'b1;
      beat_last   = rem_q == 8'h00;
    end else if (rem_q == 8'h00) begin
      beat_last = 1'b1;
    end else begin
      beat_sel[pick_idx] = 1'b1;
      beat_last = (rem_q & ~pick_val) == 8'h00;
    end
  end

  logic       run;
  logic [7:0] hi;
  assign run = state_q == S_RUN;
  assign hi  = req_value[15:8];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hflag_d = hflag_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
`ifdef ALU_CONST_HIGH_EN
    high_d  = high_q;
`endif
    if (!run) begin
      if (req_valid) begin
        state_d = S_RUN;
        rem_d   = req_value[7:0];
        hflag_d = hi == 8'hFF;
        err_d   = hi != 8'h00 && hi != 8'hFF;
        cnt_d   = 4'd0;
`ifdef ALU_CONST_HIGH_EN
        high_d  = req_high;
`endif
      end
    end else if (sel_ready) begin
      if (cnt_q != 4'(MAX_BEATS))
        cnt_d = cnt_q + 4'd1;
      if (beat_last)
        state_d = S_IDLE;
`ifdef ALU_CONST_HIGH_EN
      if (high_q)
        high_d = 1'b0;
      else
`endif
      if (hflag_q)
        hflag_d = 1'b0;
      else
        rem_d = rem_q & ~pick_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 8'h00;
      hflag_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
`ifdef ALU_CONST_HIGH_EN
      high_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hflag_q <= hflag_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef ALU_CONST_HIGH_EN
      high_q  <= high_d;
`endif
    end
  end

  assign req_ready = !run;
  assign sel_valid = run;
  assign sel       = run ? beat_sel : '0;
  assign sel_last  = run & beat_last;
  assign err       = run & err_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_const_select_encoder.sv
// Scoreboard bench for alu_const_select_encoder.
// Model expands each constant into its expected beat list.
module tb_alu_const_select_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_value;
`ifdef ALU_CONST_HIGH_EN
  logic        req_high;
`endif
  logic        sel_valid;
  logic        sel_ready;
  logic [17:0] sel;
  logic        sel_last;
  logic        err;
  logic [3:0]  beat_cnt;

  always #5 clk = ~clk;

  alu_const_select_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
`ifdef ALU_CONST_HIGH_EN
    .req_high  (req_high),
`endif
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel       (sel),
    .sel_last  (sel_last),
    .err       (err),
    .beat_cnt  (beat_cnt)
  );

  typedef struct {
    logic [17:0] sel;
    logic        last;
    logic        err;
    logic [3:0]  cnt;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  int gval[16] = '{8'haa, 8'h66, 8'h38, 8'h60,
                   8'h30, 8'h28, 8'h18, 8'h06,
                   8'h80, 8'h40, 8'h20, 8'h10,
                   8'h08, 8'h04, 8'h02, 8'h01};
  int gidx[16] = '{11, 10, 9, 13, 8, 7, 5, 12,
                   17, 16, 6, 4, 3, 15, 14, 2};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, expv);
    end
  endtask

  // Reference: list of select indices, -1 meaning "no select".
  task automatic model(input logic [15:0] v,
                       input logic h,
                       output int n);
    int idx[$];
    int hi, rem;
    logic e;
    hi  = int'(v[15:8]);
    rem = int'(v[7:0]);
    e   = hi != 0 && hi != 255;
    if (e) begin
      idx.push_back(-1);
    end else begin
      if (h) idx.push_back(0);
      if (hi == 255) idx.push_back(1);
      while (rem != 0) begin
        for (int i = 0; i < 16; i++) begin
          if ((gval[i] & rem) == gval[i]) begin
            idx.push_back(gidx[i]);
            rem = rem - gval[i];
            break;
          end
        end
      end
      if (idx.size() == 0) idx.push_back(-1);
    end
    n = idx.size();
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.sel  = '0;
      if (idx[k] >= 0) b.sel[idx[k]] = 1'b1;
      b.last = (k == n - 1);
      b.err  = e;
      b.cnt  = 4'((k > 8) ? 8 : k);
      exp_q.push_back(b);
    end
  endtask

  // Monitor: compares each accepted beat, checks stalls hold.
  logic        held = 1'b0;
  logic [17:0] p_sel;
  logic        p_last, p_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else if (sel_valid) begin
      if (held) begin
        chk("stall_sel", 32'(sel), 32'(p_sel));
        chk("stall_last", 32'(sel_last), 32'(p_last));
        chk("stall_err", 32'(err), 32'(p_err));
      end
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      if (sel_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: sel %0h", sel);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_sel", 32'(sel), 32'(b.sel));
          chk("beat_last", 32'(sel_last), 32'(b.last));
          chk("beat_err", 32'(err), 32'(b.err));
          chk("beat_cnt", 32'(beat_cnt), 32'(b.cnt));
        end
      end
      held  = !sel_ready;
      p_sel = sel;
      p_last = sel_last;
      p_err = err;
    end else begin
      held = 1'b0;
    end
  end

  task automatic wait_idle();
    int c = 0;
    while (!req_ready && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: req_ready %0b", req_ready);
    end
  endtask

  // mode 0: always ready, 1: toggle, 2: random
  task automatic run_req(input logic [15:0] v,
                         input logic h,
                         input int mode);
    int n, c;
    wait_idle();
    model(v, h, n);
    req_valid = 1'b1;
    req_value = v;
`ifdef ALU_CONST_HIGH_EN
    req_high  = h;
`endif
    sel_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_value = 16'($urandom);
`ifdef ALU_CONST_HIGH_EN
    req_high  = 1'($urandom_range(0, 1));
`endif
    chk("first_beat_latency", 32'(sel_valid), 32'd1);
    c = 0;
    while (!req_ready && c < 200) begin
      @(posedge clk); #1;
      if (mode == 1) sel_ready = ~sel_ready;
      else if (mode == 2)
        sel_ready = 1'($urandom_range(0, 1));
      else sel_ready = 1'b1;
      c++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: value %0h", v);
    end
    chk("final_beat_cnt", 32'(beat_cnt),
        32'((n > 8) ? 8 : n));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int dummy;
    logic [15:0] v;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_value = 16'h0;
    sel_ready = 1'b0;
`ifdef ALU_CONST_HIGH_EN
    req_high  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_sel_last", 32'(sel_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Abort 0x00FF after two accepted beats.
    model(16'h00FF, 1'b0, dummy);
    req_valid = 1'b1;
    req_value = 16'h00FF;
    sel_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_cnt", 32'(beat_cnt), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sel_valid", 32'(sel_valid), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_last", 32'(sel_last), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_cnt", 32'(beat_cnt), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_abort_ready", 32'(req_ready), 32'd1);

    run_req(16'h0066, 1'b0, 0);
    run_req(16'hFFFF, 1'b0, 0);
    run_req(16'h00FF, 1'b0, 1);
    run_req(16'h1234, 1'b0, 0);
    run_req(16'h0000, 1'b0, 0);
    run_req(16'hFF00, 1'b0, 2);
    run_req(16'h00AA, 1'b0, 1);
`ifdef ALU_CONST_HIGH_EN
    run_req(16'h0028, 1'b1, 0);
    run_req(16'h0000, 1'b1, 1);
    run_req(16'hFF81, 1'b1, 2);
`endif

    for (int t = 0; t < 60; t++) begin
      v[7:0] = ($urandom_range(0, 5) == 0) ?
               8'h00 : 8'($urandom);
      case ($urandom_range(0, 3))
        0: v[15:8] = 8'hFF;
        1: v[15:8] = 8'($urandom);
        default: v[15:8] = 8'h00;
      endcase
`ifdef ALU_CONST_HIGH_EN
      run_req(v, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 2)));
`else
      run_req(v, 1'b0, int'($urandom_range(0, 2)));
`endif
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
